// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: FWFT FIFO with valid/ready output,
// sticky overflow flag and saturating frame-error count. Define UART_RX_FIFO_ALMOST_FULL_EN to add almostFull.
module uart_rx_fifo #(
  parameter int Depth           = 8,
  parameter int AlmostFullLevel = 6
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output logic [7:0]             outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(Depth):0] count,
  output logic                   overflow,
  output logic [7:0]             errCount,
  input  logic                   clearFlags
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                   almostFull
`endif
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      err_count_q, err_count_d;

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign full = (count_q == DepthCnt);
  assign pop  = outValid && outReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push = rxDone && (!full || pop);
  assign drop = rxDone && full && !pop;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    err_count_d = err_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the clearing cycle must still be reported.
    if (clearFlags) overflow_d = 1'b0;
    if (drop)       overflow_d = 1'b1;

    if (clearFlags)                       err_count_d = rxErr ? 8'd1 : 8'd0;
    else if (rxErr && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: storage is deliberately not reset; valid data is tracked by count, and a reset here would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rxData;
  end

  assign outData  = mem_q[rd_ptr_q];
  assign outValid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign errCount = err_count_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [CntW-1:0] AfLevel = CntW'(AlmostFullLevel);

  logic almost_full_q, almost_full_d;

  // Registered from next count so it switches on the same edge as count.
  always_comb begin
    almost_full_d = (count_d >= AfLevel);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) almost_full_q <= 1'b0;
    else         almost_full_q <= almost_full_d;
  end

  assign almostFull = almost_full_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (Depth=8, AlmostFullLevel=6).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] errCount;
  logic       clearFlags;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almostFull;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.Depth(8), .AlmostFullLevel(6)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .rxData     (rxData),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .count      (count),
    .overflow   (overflow),
    .errCount   (errCount),
    .clearFlags (clearFlags)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almostFull (almostFull)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] b;

  initial begin
    nReset = 1'b0; rxData = '0; rxDone = 0; rxErr = 0; outReady = 0; clearFlags = 0;
    #12;
    check("reset_count", count, 0);
    check("reset_valid", outValid, 0);
    check("reset_ovf", overflow, 0);
    check("reset_err", errCount, 0);
    @(negedge clk);
    nReset = 1'b1;

    // Two bytes, then drain.
    rxDone = 1; rxData = 8'hA5; tick();
    check("first_valid", outValid, 1);
    check("first_data", outData, 8'hA5);
    rxData = 8'h3C; tick();
    rxDone = 0;
    check("two_count", count, 2);
    check("two_head", outData, 8'hA5);
    outReady = 1; tick();
    check("pop1_data", outData, 8'h3C);
    check("pop1_count", count, 1);
    tick();
    check("pop2_count", count, 0);
    check("pop2_valid", outValid, 0);
    tick();
    check("empty_ready_count", count, 0);
    check("empty_ready_valid", outValid, 0);
    outReady = 0;

    // Fill past capacity.
    for (int i = 1; i <= 9; i++) begin
      rxDone = 1; rxData = 8'(i); tick();
      if (i == 8) check("full_no_ovf", overflow, 0);
    end
    rxDone = 0;
    check("fill_count", count, 8);
    check("fill_ovf", overflow, 1);
    check("fill_head", outData, 8'h01);
    clearFlags = 1; tick(); clearFlags = 0;
    check("clear_ovf", overflow, 0);
    check("clear_keeps_count", count, 8);

    // Full with simultaneous push and pop.
    rxDone = 1; rxData = 8'h77; outReady = 1;
    check("fullpp_head", outData, 8'h01);
    tick();
    rxDone = 0;
    check("fullpp_count", count, 8);
    check("fullpp_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      b = (i == 9) ? 8'h77 : 8'(i);
      check("drain_data", outData, b);
      tick();
    end
    outReady = 0;
    check("drain_count", count, 0);

    // Error counter saturation.
    rxErr = 1;
    for (int i = 0; i < 300; i++) tick();
    rxErr = 0;
    check("err_sat", errCount, 255);

    // clearFlags coincident with a drop: overflow set wins.
    for (int i = 0; i < 8; i++) begin
      rxDone = 1; rxData = 8'(8'h10 + i); tick();
    end
    rxData = 8'hEE; clearFlags = 1; tick();
    rxDone = 0; clearFlags = 0;
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_err", errCount, 0);
    check("clr_drop_count", count, 8);
    clearFlags = 1; tick(); clearFlags = 0;
    check("clr_ovf", overflow, 0);
    clearFlags = 1; rxErr = 1; tick(); clearFlags = 0;
    check("clr_err_coinc", errCount, 1);
    tick(); rxErr = 0;
    check("err_inc", errCount, 2);
    outReady = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain2_data", outData, 8'(8'h10 + i));
      tick();
    end
    outReady = 0;
    check("drain2_count", count, 0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      b = 8'(8'hC0 + i);
      exp_q.push_back(b);
      rxDone = 1; rxData = b; tick();
    end
    outReady = 1;
    for (int i = 0; i < 40; i++) begin
      b = 8'(8'h50 + i);
      rxData = b;
      check("stream_data", outData, exp_q.pop_front());
      exp_q.push_back(b);
      tick();
      check("stream_count", count, 3);
    end
    rxDone = 0;
    while (exp_q.size() > 0) begin
      check("stream_tail", outData, exp_q.pop_front());
      tick();
    end
    outReady = 0;
    check("stream_empty", outValid, 0);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    for (int i = 1; i <= 6; i++) begin
      rxDone = 1; rxData = 8'(i); tick();
      check("af_rise", almostFull, (i >= 6) ? 1 : 0);
    end
    rxDone = 0; outReady = 1; tick(); outReady = 0;
    check("af_fall_count", count, 5);
    check("af_fall", almostFull, 0);
`endif

    // Asynchronous reset mid-stream.
    rxDone = 1; rxData = 8'h99; rxErr = 1; tick();
    rxDone = 0; rxErr = 0;
    check("pre_reset_valid", outValid, 1);
    #2;
    nReset = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_valid", outValid, 0);
    check("async_ovf", overflow, 0);
    check("async_err", errCount, 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    check("async_af", almostFull, 0);
`endif
    @(negedge clk);
    nReset = 1'b1;
    tick();
    check("post_reset_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each completed byte on the receiver's single-cycle done strobe, holds up to Depth bytes in a first-word-fall-through FIFO, and presents them to the bus/host side through a valid/ready handshake. Also keeps a sticky overflow flag and a saturating count of frame errors reported by the receiver.

## Interface

- Depth, default 8: FIFO capacity in bytes; power of two, ≥ 2.
- AlmostFullLevel, default 6: occupancy threshold for almostFull; 1 ≤ AlmostFullLevel ≤ Depth. Used only with UART_RX_FIFO_ALMOST_FULL_EN.

- clk  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- rxData  input  8  received byte from the UART receiver; sampled only in a cycle with rxDone=1.
- rxDone  input  1  one-cycle strobe from the receiver: rxData holds a completed byte.
- rxErr  input  1  one-cycle strobe from the receiver: frame error detected.
- outData  output  8  head-of-FIFO byte; valid while outValid=1.
- outValid  output  1  FIFO non-empty.
- outReady  input  1  consumer accepts the head byte when outValid && outReady.
- count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
- overflow  output  1  sticky: a byte arrived while full and was dropped.
- errCount  output  8  saturating count of rxErr strobes.
- clearFlags  input  1  synchronous clear of overflow and errCount.
- almostFull  output  1  present only with UART_RX_FIFO_ALMOST_FULL_EN.

## Operation

- Storage: Depth×8 array with write and read pointers of $clog2(Depth) bits. Both wrap modulo Depth. Occupancy is held in count.
- push = rxDone && (count < Depth || pop). pop = outValid && outReady.
- On push: write rxData at the write pointer, then advance the write pointer.
- On pop: advance the read pointer.
- count update: push only → +1; pop only → −1; both or neither → unchanged.
- Full with rxDone and pop in the same cycle: the pop frees a slot, so the push is accepted. Count stays Depth and overflow is not set.
- Full with rxDone and no pop: the byte is dropped. Pointers and count are unchanged, and overflow is set to 1.
- Empty with rxDone: the byte is pushed. outValid rises on the next cycle; there is no same-cycle bypass.
- outReady while empty: ignored. Nothing changes.
- outData = mem[rdPtr], combinational from the registered pointer. outValid = (count != 0).
- errCount: +1 per cycle with rxErr=1, saturating at 255. An rxErr strobe has no effect on FIFO contents. rxDone and rxErr in the same cycle are handled independently.
- clearFlags: on the next edge overflow ← 0 and errCount ← 0.
  - If a drop happens in the same cycle, overflow ends at 1 (set wins).
  - If rxErr=1 in the same cycle, errCount ends at 1.
- Reset: pointers 0, count 0, outValid 0, overflow 0, errCount 0, almostFull 0. Array contents are not reset, and outData is undefined while outValid=0.
- Reset asserted mid-operation discards all buffered bytes immediately (asynchronous).

## Timing

- Write-to-read latency: rxDone at edge N → outValid=1 and outData=byte after edge N.
- Pop takes effect at the edge where outValid && outReady. The next byte, if any, is presented immediately after that edge.
- Sustained throughput is one push and one pop per cycle.
- count, overflow, errCount and almostFull are registered outputs. No output depends combinationally on rxDone, rxErr or outReady.
- Handshake rule: once outValid=1, outData stays stable until popped, regardless of later pushes.

## Configuration

- UART_RX_FIFO_ALMOST_FULL_EN defined:
  - almostFull port exists.
  - almostFull is a register equal to (next count ≥ AlmostFullLevel), so it is valid on the same edge count updates.
  - Intended for flow-control/interrupt logic.
- UART_RX_FIFO_ALMOST_FULL_EN undefined:
  - The port and its logic are absent; AlmostFullLevel is ignored.
  - All other behaviour is identical.

## Test plan

- Reset, then push 0xA5, 0x3C with outReady=0 → count=2, outData=0xA5. Raise outReady for 2 cycles → 0xA5 then 0x3C delivered, count=0, outValid=0.
- Depth=8: push 9 bytes 0x01..0x09 with no pops → count=8, overflow=1, and pops return 0x01..0x08 with 0x09 absent.
- Full FIFO: rxDone with 0x77 in the same cycle as a pop → count stays 8, overflow=0, and 0x77 is the last byte out.
- 300 rxErr strobes → errCount=255. Then clearFlags → errCount=0 and overflow=0. clearFlags coincident with rxErr → errCount=1.
- Continuous push and pop every cycle for 40 cycles across pointer wrap → output order matches input order and count is constant.
- With UART_RX_FIFO_ALMOST_FULL_EN and AlmostFullLevel=6: almostFull rises with the push making count=6 and falls with the pop making count=5. Assert nReset mid-stream → all outputs return to 0 immediately.
